// File: rtl/csa_accum_ctrl.sv
`default_nettype none
// ============================================================================
// csa_accum_ctrl : carry-save accumulator controller with iterative resolve
// Rev 1.0
// ============================================================================
module csa_accum_ctrl #(
  parameter int WIDTH = 4,
  parameter int ACC_W = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [CNT_W-1:0] out_count
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCUM   = 2'd1,
    RESOLVE = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t           state_q;
  logic [ACC_W-1:0] s_q;
  logic [ACC_W-1:0] c_q;
  logic [CNT_W-1:0] cnt_q;

  logic [ACC_W-1:0] x_ext;
  logic [ACC_W-1:0] csa_sum_d;
  logic [ACC_W-1:0] csa_carry_d;
  logic [ACC_W-1:0] res_sum_d;
  logic [ACC_W-1:0] res_carry_d;
  logic [CNT_W-1:0] cnt_inc_d;
  logic             accept;

  assign x_ext  = ACC_W'(in_data);
  assign accept = in_valid && in_ready;

  // Left shifts drop the carry out of the MSB, giving the modulo-2^ACC_W wrap.
  assign csa_sum_d   = s_q ^ c_q ^ x_ext;
  assign csa_carry_d = ((s_q & c_q) | (c_q & x_ext) | (x_ext & s_q)) << 1;
  assign res_sum_d   = s_q ^ c_q;
  assign res_carry_d = (s_q & c_q) << 1;
  assign cnt_inc_d   = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      s_q     <= '0;
      c_q     <= '0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            s_q     <= x_ext;
            c_q     <= '0;
            cnt_q   <= CNT_W'(1);
            state_q <= in_last ? RESOLVE : ACCUM;
          end
        end
        ACCUM: begin
          if (accept) begin
            s_q     <= csa_sum_d;
            c_q     <= csa_carry_d;
            cnt_q   <= cnt_inc_d;
            state_q <= in_last ? RESOLVE : ACCUM;
          end
        end
        RESOLVE: begin
          if (c_q == '0) begin
            state_q <= DONE;
          end else begin
            s_q <= res_sum_d;
            c_q <= res_carry_d;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = ((state_q == IDLE) || (state_q == ACCUM)) && !rst;
  assign out_valid = (state_q == DONE);
  assign out_sum   = s_q;
  assign out_count = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_csa_accum_ctrl.sv
`default_nettype none
// tb_csa_accum_ctrl : directed scoreboard bench for csa_accum_ctrl.
module tb_csa_accum_ctrl;

  localparam int WIDTH = 4;
  localparam int ACC_W = 8;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_data = '0;
  logic             in_last = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [ACC_W-1:0] out_sum;
  logic [CNT_W-1:0] out_count;

  // Second instance with a narrow counter for the saturation case
  logic             b_in_valid = 1'b0;
  logic             b_in_ready;
  logic [WIDTH-1:0] b_in_data = '0;
  logic             b_in_last = 1'b0;
  logic             b_out_valid;
  logic             b_out_ready = 1'b1;
  logic [ACC_W-1:0] b_out_sum;
  logic [1:0]       b_out_count;

  always #5 clk = ~clk;

  csa_accum_ctrl #(.WIDTH(WIDTH), .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum), .out_count(out_count)
  );

  csa_accum_ctrl #(.WIDTH(WIDTH), .ACC_W(ACC_W), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data), .in_last(b_in_last),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_sum(b_out_sum), .out_count(b_out_count)
  );

  typedef struct {
    logic [ACC_W-1:0] sum;
    logic [CNT_W-1:0] cnt;
    int               min_lat;
    int               max_lat;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  time  t_last = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input int sum, input int cnt, input int mn, input int mx);
    exp_t e;
    e.sum = ACC_W'(sum);
    e.cnt = CNT_W'(cnt);
    e.min_lat = mn;
    e.max_lat = mx;
    sb_q.push_back(e);
  endtask

  // Present one operand and hold it until accepted; optionally require same-cycle accept.
  task automatic send(input int d, input bit last, input bit must_be_immediate);
    int  n;
    bit  rdy;
    in_valid = 1'b1;
    in_data  = WIDTH'(d);
    in_last  = last;
    n = 0;
    rdy = 1'b0;
    while (!rdy && n < 200) begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk);
      n++;
    end
    if (!rdy) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: operand %0d never accepted", d);
    end else if (must_be_immediate) begin
      chk("accept_no_stall", n, 1);
    end
    if (last) t_last = $time;
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic idle_cycles(input int n, input bit junk_last);
    in_valid = 1'b0;
    in_last  = junk_last;
    repeat (n) @(posedge clk);
    #1;
    in_last = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((sb_q.size() != 0 || out_valid) && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (n >= 100) begin
      checks++;
      errors++;
      $display("FAIL %s_drain_timeout: %0d results outstanding", name, sb_q.size());
    end
  endtask

  // Monitor: pops the scoreboard on each output handshake, checks hold under backpressure.
  initial begin
    bit               pv;
    bit               pr;
    bit               chk_rdy;
    logic [ACC_W-1:0] ps;
    logic [CNT_W-1:0] pc;
    int               lat;
    exp_t             e;
    pv = 1'b0; pr = 1'b0; chk_rdy = 1'b0; ps = '0; pc = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pv = 1'b0;
        chk_rdy = 1'b0;
      end else begin
        if (chk_rdy) begin
          chk("in_ready_after_handshake", in_ready, 1);
          chk_rdy = 1'b0;
        end
        if (out_valid && !pv) begin
          lat = int'(($time - t_last - 5) / 10);
          checks++;
          if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_out_valid: got sum %0d count %0d, required no result", out_sum, out_count);
          end else if (lat < sb_q[0].min_lat || lat > sb_q[0].max_lat) begin
            errors++;
            $display("FAIL resolve_latency: got %0d cycles, required %0d..%0d", lat, sb_q[0].min_lat, sb_q[0].max_lat);
          end
        end
        if (pv && !pr) begin
          chk("valid_held", out_valid, 1);
          chk("sum_held", out_sum, ps);
          chk("count_held", out_count, pc);
        end
        if (out_valid) chk("in_ready_low_in_done", in_ready, 0);
        if (out_valid && out_ready) begin
          if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_result: got sum %0d count %0d, required none", out_sum, out_count);
          end else begin
            e = sb_q.pop_front();
            chk("out_sum", out_sum, e.sum);
            chk("out_count", out_count, e.cnt);
          end
          chk_rdy = 1'b1;
        end
        pv = out_valid;
        pr = out_ready;
        ps = out_sum;
        pc = out_count;
      end
    end
  end

  initial begin
    int n;
    // Reset state
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_sum", out_sum, 0);
    chk("rst_out_count", out_count, 0);
    chk("rst_in_ready", in_ready, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("in_ready_after_reset", in_ready, 1);
    @(posedge clk);
    #1;

    // Single operand with last: result one cycle later
    push_exp(9, 1, 1, 1);
    send(9, 1'b1, 1'b1);
    wait_drain("single");

    // Four back-to-back 15s
    push_exp(60, 4, 1, ACC_W + 1);
    send(15, 1'b0, 1'b1);
    send(15, 1'b0, 1'b1);
    send(15, 1'b0, 1'b1);
    send(15, 1'b1, 1'b1);
    wait_drain("b2b");

    // Twenty 15s with gaps; stray in_last during gaps must be ignored
    push_exp(44, 20, 1, ACC_W + 1);
    for (int i = 0; i < 20; i++) begin
      if (i > 0) idle_cycles($urandom_range(0, 2), (i % 3) == 0);
      send(15, i == 19, 1'b0);
    end
    wait_drain("gaps");

    // Result backpressure
    out_ready = 1'b0;
    push_exp(3, 1, 1, 1);
    send(3, 1'b1, 1'b1);
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("bp_valid_seen", out_valid, 1);
    repeat (5) @(posedge clk);
    #1 out_ready = 1'b1;
    wait_drain("backpressure");

    // Reset mid-resolve of 7,8,9 discards the batch
    send(7, 1'b0, 1'b1);
    send(8, 1'b0, 1'b1);
    send(9, 1'b1, 1'b1);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_count", out_count, 0);
    chk("mid_rst_sum", out_sum, 0);
    repeat (12) @(posedge clk);
    #1;
    push_exp(3, 2, 1, ACC_W + 1);
    send(1, 1'b0, 1'b1);
    send(2, 1'b1, 1'b1);
    wait_drain("after_reset");

    // Counter saturation on the narrow-counter instance
    for (int i = 0; i < 5; i++) begin
      b_in_valid = 1'b1;
      b_in_data  = WIDTH'(1);
      b_in_last  = (i == 4);
      @(negedge clk);
      chk("sat_in_ready", b_in_ready, 1);
      @(posedge clk);
      #1;
    end
    b_in_valid = 1'b0;
    b_in_last  = 1'b0;
    n = 0;
    @(negedge clk);
    while (!b_out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("sat_out_valid", b_out_valid, 1);
    chk("sat_out_count", b_out_count, 3);
    chk("sat_out_sum", b_out_sum, 5);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/csa_accum_ctrl.md
# csa_accum_ctrl

Sequential controller that drives a carry-save adder datapath to sum a variable-length stream of unsigned operands. Each accepted operand is folded into a redundant (sum, carry) register pair in one cycle with no carry propagation. After the last operand, an iterative resolve phase propagates carries until the carry vector is zero. The block sits between an operand producer and a result consumer, with valid/ready handshakes on both sides.

## Interface
- WIDTH, 4: operand width in bits.
- ACC_W, 8: accumulator width in bits. Must satisfy ACC_W >= WIDTH. Results wrap modulo 2^ACC_W.
- CNT_W, 8: operand counter width.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand valid.
- in_ready  out  1  controller can accept an operand.
- in_data  in  WIDTH  unsigned operand, zero-extended to ACC_W.
- in_last  in  1  marks the final operand of a batch; sampled with the operand.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_sum  out  ACC_W  resolved sum, modulo 2^ACC_W.
- out_count  out  CNT_W  number of operands in the batch; saturates at 2^CNT_W-1.

## Operation
- Internal registers: S[ACC_W-1:0], C[ACC_W-1:0], cnt[CNT_W-1:0], state.
- States: IDLE, ACCUM, RESOLVE, DONE.
- Accept event: in_valid && in_ready at a rising edge.
- in_ready = (state==IDLE || state==ACCUM) && !rst.
- out_valid = (state==DONE). out_sum = S. out_count = cnt.
- **IDLE**, on accept:
  - S <= X (zero-extended operand), C <= 0, cnt <= 1.
  - Next state is RESOLVE if in_last, else ACCUM.
- **ACCUM**, on accept (carry-save step):
  - S <= S ^ C ^ X.
  - C <= ((S&C)|(C&X)|(X&S)) << 1, truncated to ACC_W.
  - cnt <= cnt+1, saturating.
  - Next state is RESOLVE if in_last, else stay in ACCUM.
  - No accept leaves all registers unchanged; gaps in in_valid are legal.
- **RESOLVE**, evaluated every cycle:
  - If C==0: go to DONE; S and C unchanged.
  - Else: S <= S ^ C, C <= (S & C) << 1 truncated, stay in RESOLVE.
  - Converges in at most ACC_W iterations. Carries shifted out of bit ACC_W-1 are discarded, which gives the modulo wrap.
- **DONE**:
  - out_sum and out_count are held stable while out_ready=0.
  - On out_valid && out_ready: go to IDLE. S, C and cnt keep their values until the next IDLE accept.
- Invariant: in ACCUM, S+C (mod 2^ACC_W) equals the sum of the accepted operands (mod 2^ACC_W).
- Reset at any time, including mid-RESOLVE or in DONE: state <= IDLE, S <= 0, C <= 0, cnt <= 0. The in-progress batch is discarded and no out_valid pulse is produced.

## Timing
- Reset values: out_valid=0, out_sum=0, out_count=0. in_ready=0 during the reset cycle and 1 in the first cycle after reset.
- Each operand costs one cycle; back-to-back accepts are sustained at 1 operand/cycle.
- Let the last operand be accepted at edge t, and let k be the number of nonzero-C iterations (0 <= k <= ACC_W).
  - RESOLVE occupies cycles t+1 .. t+k+1.
  - out_valid rises after edge t+k+1.
  - Latency from the last-beat edge to out_valid is k+1 cycles (minimum 1, maximum ACC_W+1).
- in_ready=0 from RESOLVE entry until the cycle after DONE exits.
- The earliest new operand accept is the edge after the out handshake edge; there is no same-edge result/operand overlap.
- in_last on a non-accepted cycle is ignored.

## Test plan
- Single operand 9 with in_last, then out_ready=1 held: out_valid is 1 exactly 1 cycle after the accept edge, out_sum=9, out_count=1, and in_ready=1 on the cycle after the handshake.
- Operands 15,15,15,15 back-to-back, last on the 4th: in_ready stays 1 for all 4 cycles, out_sum=60, out_count=4, and the resolve latency is at most 9 cycles.
- 20 operands of 15 with random in_valid gaps: out_sum=44 (300 mod 256), out_count=20.
- Result backpressure: out_ready=0 for 5 cycles after out_valid. out_valid, out_sum and out_count stay stable and in_ready stays 0. On out_ready=1 the handshake completes and state returns to IDLE.
- Reset asserted for 1 cycle during RESOLVE of the batch 7,8,9: out_valid never rises. The following batch 1,2 with last then produces out_sum=3, out_count=2.
- Operand counter saturation (CNT_W=2): 5 operands of 1 produce out_count=3 and out_sum=5.
